// File: rtl/leg_alu_issue.sv
// leg_alu_issue: issues one instruction at a time to an external ALU, fetching
// operands from a six-entry register file and writing results back.
module leg_alu_issue #(
  parameter int UUID = 0,
  parameter     NAME = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [7:0]  io_in,
  output logic [7:0]  alu_opcode,
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  alu_carry,
  output logic        result_valid,
  output logic [2:0]  result_dest,
  output logic [7:0]  result_data,
  output logic [7:0]  skip_count
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, WB_HI} state_t;

  state_t     state_q, state_d;
  logic [7:0] regs [6];
  logic [5:0] op_q;        // {imm1, imm2, alu op[3:0]}
  logic [7:0] arg1_q, arg2_q;
  logic [2:0] dest_q;
  logic [7:0] op1_q, op2_q, res_lo_q, res_hi_q;
  logic [7:0] skip_q;
  logic       rv_q;
  logic [2:0] rdest_q;
  logic [7:0] rdata_q;

  logic       hs, is_exec;
  logic [7:0] rd1, rd2;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  always_comb begin
    is_exec = !instr[5] && (instr[3:0] inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11, 4'd12});
    hs      = instr_valid && instr_ready;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_opcode  = 8'h20;
    alu_in1     = '0;
    alu_in2     = '0;
    case (state_q)
      IDLE: begin
        instr_ready = rst;
        if (hs && is_exec) state_d = READ;
      end
      READ: state_d = EXEC;
      EXEC: begin
        alu_opcode = {4'b0, op_q[3:0]};
        alu_in1    = op1_q;
        alu_in2    = op2_q;
        state_d    = WB;
      end
      WB:      state_d = (op_q[3:0] == 4'd12) ? WB_HI : IDLE;
      WB_HI:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address 6 reads zero, 7 reads io_in; only 0..5 are backed by storage.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (arg1_q[2:0] == 3'(i)) rd1 = regs[i];
      if (arg2_q[2:0] == 3'(i)) rd2 = regs[i];
    end
    if (arg1_q[2:0] == 3'd7) rd1 = io_in;
    if (arg2_q[2:0] == 3'd7) rd2 = io_in;
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = dest_q;
    wr_data = res_lo_q;
    if (state_q == WB) begin
      wr_en = 1'b1;
    end else if (state_q == WB_HI) begin
      wr_en   = 1'b1;
      wr_addr = dest_q + 3'd1;
      wr_data = res_hi_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      arg1_q   <= '0;
      arg2_q   <= '0;
      dest_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      skip_q   <= '0;
      rv_q     <= 1'b0;
      rdest_q  <= '0;
      rdata_q  <= '0;
      for (int unsigned i = 0; i < 6; i++) regs[i] <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= wr_en;
      rdest_q <= wr_en ? wr_addr : '0;
      rdata_q <= wr_en ? wr_data : '0;
      case (state_q)
        IDLE: if (hs) begin
          if (is_exec) begin
            op_q   <= {instr[7:6], instr[3:0]};
            arg1_q <= instr[15:8];
            arg2_q <= instr[23:16];
            dest_q <= instr[26:24];
          end else begin
            skip_q <= skip_q + 8'd1;
          end
        end
        READ: begin
          op1_q <= op_q[5] ? arg1_q : rd1;
          op2_q <= op_q[4] ? arg2_q : rd2;
        end
        EXEC: begin
          res_lo_q <= alu_result;
          res_hi_q <= alu_carry;
        end
        default: ;
      endcase
      // Writes to addresses 6 and 7 match no entry and are dropped.
      if (wr_en) begin
        for (int unsigned i = 0; i < 6; i++)
          if (wr_addr == 3'(i)) regs[i] <= wr_data;
      end
    end
  end

  always_comb begin
    result_valid = rv_q;
    result_dest  = rdest_q;
    result_data  = rdata_q;
    skip_count   = skip_q;
  end

endmodule

// File: tb/tb_leg_alu_issue.sv
// Bench for leg_alu_issue: a stub ALU, a cycle-timed behavioural model with a
// per-cycle compare process, directed literal checks and a random phase.
module tb_leg_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [7:0]  io_in = 8'h5A;
  logic        instr_ready;
  logic [7:0]  alu_opcode, alu_in1, alu_in2, alu_result, alu_carry;
  logic        result_valid;
  logic [2:0]  result_dest;
  logic [7:0]  result_data, skip_count;

  int checks = 0;
  int errors = 0;

  leg_alu_issue #(.UUID(3), .NAME("issue0")) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .io_in(io_in), .alu_opcode(alu_opcode), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_result(alu_result), .alu_carry(alu_carry),
    .result_valid(result_valid), .result_dest(result_dest),
    .result_data(result_data), .skip_count(skip_count)
  );

  always #5 clk = ~clk;

  // Stub ALU: {carry, result}; carry is junk except for multiply.
  function automatic logic [15:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = {8'h00, a} * {8'h00, b};
    case (op)
      8'h00:   return {~a, 8'(a + b)};
      8'h01:   return {~b, 8'(a - b)};
      8'h02:   return {a, a & b};
      8'h03:   return {b, a | b};
      8'h04:   return {8'h5A, a ^ b};
      8'h05:   return {a, ~a};
      8'h0B:   return {b, 8'(b - a)};
      8'h0C:   return p;
      default: return 16'hEEEE;
    endcase
  endfunction

  assign {alu_carry, alu_result} = alu_fn(alu_opcode, alu_in1, alu_in2);

  // ---------------- behavioural model ----------------
  logic [7:0]  m_reg [8];
  logic [7:0]  m_skip = '0;
  logic        m_rdy = 1'b0;
  logic [7:0]  m_op, m_a1, m_a2, m_dest;
  logic [15:0] m_res;
  int cyc = 0, busy_until = 0, rd_cyc = -1, wb_cyc = -1, hi_cyc = -1;
  logic       e_valid = 1'b0;
  logic [2:0] e_dest = '0;
  logic [7:0] e_data = '0, e_aop = 8'h20, e_a1 = '0, e_a2 = '0;

  logic [3:0] nibs [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd11, 4'd12};

  function automatic logic exec_op(input logic [7:0] op);
    return !op[5] && (op[3:0] <= 4'd5 || op[3:0] == 4'd11 || op[3:0] == 4'd12);
  endfunction

  function automatic logic [7:0] mread(input logic [2:0] a);
    if (a == 3'd6) return 8'h00;
    if (a == 3'd7) return io_in;
    return m_reg[a];
  endfunction

  always begin : model
    logic [7:0] a, b;
    logic [2:0] d;
    @(posedge clk);
    cyc = cyc + 1;
    e_valid = 1'b0; e_dest = '0; e_data = '0;
    e_aop = 8'h20; e_a1 = '0; e_a2 = '0;
    if (!rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_skip = '0; busy_until = 0; rd_cyc = -1; wb_cyc = -1; hi_cyc = -1;
      m_rdy = 1'b1;
    end else begin
      if (cyc == wb_cyc) begin
        d = m_dest[2:0];
        if (d < 3'd6) m_reg[d] = m_res[7:0];
        e_valid = 1'b1; e_dest = d; e_data = m_res[7:0];
      end
      if (cyc == hi_cyc) begin
        d = m_dest[2:0] + 3'd1;
        if (d < 3'd6) m_reg[d] = m_res[15:8];
        e_valid = 1'b1; e_dest = d; e_data = m_res[15:8];
      end
      if (cyc == rd_cyc) begin
        a = m_op[7] ? m_a1 : mread(m_a1[2:0]);
        b = m_op[6] ? m_a2 : mread(m_a2[2:0]);
        e_aop = {4'h0, m_op[3:0]}; e_a1 = a; e_a2 = b;
        m_res = alu_fn(e_aop, a, b);
      end
      if (m_rdy && instr_valid) begin
        if (exec_op(instr[7:0])) begin
          m_op = instr[7:0]; m_a1 = instr[15:8]; m_a2 = instr[23:16]; m_dest = instr[31:24];
          rd_cyc = cyc + 1;
          wb_cyc = cyc + 3;
          hi_cyc = (instr[3:0] == 4'd12) ? cyc + 4 : -1;
          busy_until = (instr[3:0] == 4'd12) ? cyc + 4 : cyc + 3;
        end else begin
          m_skip = m_skip + 8'd1;
        end
      end
      m_rdy = (cyc >= busy_until);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // ---------------- per-cycle compare + logging ----------------
  typedef struct { int c; logic [2:0] d; logic [7:0] v; } wb_t;
  typedef struct { logic [7:0] op; logic [7:0] a; logic [7:0] b; } alu_t;
  wb_t  wb_log[$];
  alu_t alu_log[$];
  int   low_run = 0, last_low_run = 0;

  always begin : compare
    @(negedge clk);
    #2;
    if (!rst) begin
      chk("rst_ready", instr_ready, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_dest", result_dest, 0);
      chk("rst_data", result_data, 0);
      chk("rst_aluop", alu_opcode, 8'h20);
      chk("rst_in1", alu_in1, 0);
      chk("rst_in2", alu_in2, 0);
      chk("rst_skip", skip_count, 0);
    end else begin
      chk("ready", instr_ready, m_rdy);
      chk("valid", result_valid, e_valid);
      chk("dest", result_dest, e_dest);
      chk("data", result_data, e_data);
      chk("aluop", alu_opcode, e_aop);
      chk("in1", alu_in1, e_a1);
      chk("in2", alu_in2, e_a2);
      chk("skip", skip_count, m_skip);
      if (result_valid) wb_log.push_back('{cyc, result_dest, result_data});
      if (alu_opcode != 8'h20) alu_log.push_back('{alu_opcode, alu_in1, alu_in2});
      if (!instr_ready) low_run++;
      else if (low_run != 0) begin last_low_run = low_run; low_run = 0; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [31:0] w, output int hs);
    int t;
    t = 0; hs = -1;
    instr = w; instr_valid = 1'b1;
    while (hs < 0 && t <= 50) begin
      if (instr_ready === 1'b1) hs = cyc + 1;
      @(negedge clk);
      t++;
    end
    instr_valid = 1'b0;
    if (hs < 0) begin
      checks++; errors++;
      $display("FAIL send_timeout actual=no_handshake expected=handshake instr=%08h", w);
    end
  endtask

  task automatic readreg(input logic [2:0] r, input logic [7:0] exp, input string nm);
    int hs;
    wb_log.delete();
    send({8'd6, 8'd0, 5'd0, r, 8'h40}, hs);
    repeat (7) @(negedge clk);
    chk({nm, "_n"}, wb_log.size(), 1);
    if (wb_log.size() == 1) begin
      chk(nm, wb_log[0].v, exp);
      chk({nm, "_d"}, wb_log[0].d, 6);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    int hs, hs2;
    logic [31:0] w;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // ADD imm/imm -> r2 = 12
    wb_log.delete(); alu_log.delete();
    send(32'h02_07_05_C0, hs);
    repeat (7) @(negedge clk);
    chk("add_n", wb_log.size(), 1);
    if (wb_log.size() == 1) begin
      chk("add_dest", wb_log[0].d, 2);
      chk("add_data", wb_log[0].v, 8'h0C);
      chk("add_lat", wb_log[0].c, hs + 3);
    end
    chk("add_alu_n", alu_log.size(), 1);
    if (alu_log.size() == 1) chk("add_aluop", alu_log[0].op, 8'h00);
    readreg(3'd2, 8'h0C, "r2_add");

    // SUB reg/imm -> r3 = 12 - 20
    wb_log.delete(); alu_log.delete();
    send(32'h03_14_02_41, hs);
    repeat (7) @(negedge clk);
    chk("sub_alu_n", alu_log.size(), 1);
    if (alu_log.size() == 1) begin
      chk("sub_in1", alu_log[0].a, 8'd12);
      chk("sub_in2", alu_log[0].b, 8'd20);
    end
    readreg(3'd3, 8'hF8, "r3_sub");

    // MUL 200*3 -> r0 = 0x58, r1 = 0x02
    wb_log.delete();
    send(32'h00_03_C8_CC, hs);
    repeat (7) @(negedge clk);
    chk("mul_lowrun", last_low_run, 4);
    chk("mul_n", wb_log.size(), 2);
    if (wb_log.size() == 2) begin
      chk("mul_d0", wb_log[0].d, 0);
      chk("mul_v0", wb_log[0].v, 8'h58);
      chk("mul_d1", wb_log[1].d, 1);
      chk("mul_v1", wb_log[1].v, 8'h02);
      chk("mul_consec", wb_log[1].c, wb_log[0].c + 1);
      chk("mul_lat", wb_log[0].c, hs + 3);
    end
    readreg(3'd0, 8'h58, "r0_mul");
    readreg(3'd1, 8'h02, "r1_mul");
    readreg(3'd7, 8'h5A, "r7_io");

    // MUL 0x10*0x10 to r5: high byte targets dropped address 6
    wb_log.delete();
    send(32'h05_10_10_CC, hs);
    repeat (7) @(negedge clk);
    chk("mul2_n", wb_log.size(), 2);
    if (wb_log.size() == 2) begin
      chk("mul2_v0", wb_log[0].v, 8'h00);
      chk("mul2_d1", wb_log[1].d, 6);
      chk("mul2_v1", wb_log[1].v, 8'h01);
    end
    readreg(3'd5, 8'h00, "r5_mul2");
    readreg(3'd6, 8'h00, "r6_zero");

    // Non-executable opcodes back-to-back
    wb_log.delete(); alu_log.delete();
    send(32'h01_02_03_20, hs);
    send(32'h01_02_03_07, hs2);
    repeat (3) @(negedge clk);
    chk("skip_consec", hs2, hs + 1);
    chk("skip_count", skip_count, 8'd2);
    chk("skip_wb", wb_log.size(), 0);
    chk("skip_alu", alu_log.size(), 0);

    // Reset during EXEC aborts the writeback and clears registers
    wb_log.delete();
    send(32'h04_01_01_C0, hs);
    @(negedge clk);
    #1 chk("exec_aluop", alu_opcode, 8'h00);
    rst = 1'b0;
    #1 chk("abort_aluop", alu_opcode, 8'h20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_wb", wb_log.size(), 0);
    readreg(3'd0, 8'h00, "r0_clr");
    readreg(3'd1, 8'h00, "r1_clr");
    readreg(3'd3, 8'h00, "r3_clr");
    readreg(3'd2, 8'h00, "r2_clr");
    wb_log.delete();
    send(32'h02_07_05_C0, hs);
    repeat (7) @(negedge clk);
    chk("post_n", wb_log.size(), 1);
    if (wb_log.size() == 1) chk("post_data", wb_log[0].v, 8'h0C);

    // Random phase, checked by the model every cycle
    for (int i = 0; i < 800; i++) begin
      w = $urandom();
      if ($urandom_range(0, 3) != 0) begin
        w[5] = 1'b0;
        w[3:0] = nibs[$urandom_range(0, 7)];
      end
      instr = w;
      instr_valid = ($urandom_range(0, 3) != 0);
      if (i % 7 == 0) io_in = 8'($urandom_range(0, 255));
      if (i == 400) rst = 1'b0;
      if (i == 403) rst = 1'b1;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    repeat (8) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
